// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment glyph table and display-word type for the seg7 scan driver
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  // Active-low {g,f,e,d,c,b,a} glyphs for nibbles 0-F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct packed {
    logic [15:0] digits;
    logic        dp_en;
    logic [1:0]  dp_pos;
  } word_t;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load handshake and display pins of the scan driver
//   load_valid/load_ready/digits_bcd/dp_en/dp_pos : word offer handshake
//   an/seg/dp_n                                   : active-low display drive
interface seg7_scan_driver_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] digits_bcd;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  modport master (output load_valid, digits_bcd, dp_en, dp_pos, input load_ready, an, seg, dp_n);
  modport slave (input load_valid, digits_bcd, dp_en, dp_pos, output load_ready, an, seg, dp_n);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low 7-segment glyph
//   i_nib : hex nibble
//   o_seg : {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment driver with frame-synchronous word update
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seg7_scan_driver_if.slave (load handshake in, an/seg/dp_n out)
//   SEG7_LZ_BLANK_EN : when defined, leading zero digits (k>=1) are blanked
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int REFRESH_HZ = 250,
  parameter int TICK_DIV   = CLK_HZ / (4 * REFRESH_HZ)
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int TW = TICK_DIV > 2 ? $clog2(TICK_DIV) : 1;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_idx;
  word_t         r_active, r_shadow;
  logic          r_pending;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic          w_wrap, w_frame, w_xfer, w_dp_n;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph, w_seg;
  assign w_wrap  = r_tick == TW'(TICK_DIV - 1);
  assign w_frame = w_wrap && r_idx == 2'(NUM_DIGITS - 1);
  assign w_xfer  = bus.load_valid && !r_pending;
  assign w_nib   = r_active.digits[r_idx*4 +: 4];
  assign w_dp_n  = !(r_active.dp_en && r_active.dp_pos == r_idx);
  seg7_decode u_decode (.i_nib(w_nib), .o_seg(w_glyph));
`ifdef SEG7_LZ_BLANK_EN
  logic w_blank;
  // Blank when this and all higher nibbles are zero, unless a visible decimal point sits at or left of it
  assign w_blank = r_idx != 2'd0 && (r_active.digits >> {r_idx, 2'b00}) == 16'd0
                   && !(r_active.dp_en && r_active.dp_pos >= r_idx);
  assign w_seg   = w_blank ? 7'h7F : w_glyph;
`else
  assign w_seg   = w_glyph;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else begin
      r_tick <= w_wrap ? '0 : r_tick + 1'b1;
      if (w_wrap) r_idx <= r_idx + 1'b1;
    end
  end
  // Commit and capture are exclusive: capture needs pending=0, commit needs pending=1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_frame && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= '{digits: bus.digits_bcd, dp_en: bus.dp_en, dp_pos: bus.dp_pos};
      r_pending <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an   <= 4'hF;
      r_seg  <= 7'h7F;
      r_dp_n <= 1'b1;
    end else begin
      r_an   <= ~(4'b0001 << r_idx);
      r_seg  <= w_seg;
      r_dp_n <= w_dp_n;
    end
  end
  assign bus.load_ready = !r_pending;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp_n       = r_dp_n;
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 10_000_000, system clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 250, full 4-digit frame rate in Hz.
REQ-003 Parameter TICK_DIV, default CLK_HZ/(4*REFRESH_HZ) = 10000, clock cycles per digit slot; minimum 2.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load_valid  input  1  new display word offered.
REQ-007 load_ready  output  1  block can accept a word.
REQ-008 digits_bcd  input  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-009 dp_en  input  1  decimal point enable for the offered word.
REQ-010 dp_pos  input  2  digit index carrying the decimal point.
REQ-011 an  output  4  digit enables, active-low, one-hot-low while scanning.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp_n  output  1  decimal point segment, active-low.

Function
REQ-014 The tick counter SHALL count 0..TICK_DIV-1 and wrap; each wrap SHALL advance the digit index 0->1->2->3->0.
REQ-015 A frame boundary SHALL be a tick wrap while the digit index is 3.
REQ-016 Transfer SHALL occur on a cycle with load_valid=1 and load_ready=1; the word is captured into a shadow register and pending is set.
REQ-017 load_ready SHALL equal NOT pending.
REQ-018 At a frame boundary with pending=1, the shadow SHALL be copied to the active register and pending cleared in that same cycle.
REQ-019 A transfer on the frame-boundary cycle with pending=0 SHALL be committed at the following boundary, not the current one.
REQ-020 an, seg and dp_n SHALL be registered and reflect the digit index and active register with exactly one cycle of latency.
REQ-021 Nibbles 0-9 SHALL decode to the standard pattern (0 = 1000000, 7 = 1111000); nibbles A-F SHALL decode to hex glyphs (A = 0001000, F = 0001110).
REQ-022 dp_n SHALL be 0 only while the scanned digit equals dp_pos and dp_en=1 in the active register.
REQ-023 The active register SHALL never change except at a frame boundary, so no frame mixes two words.

Reset
REQ-024 While rst=1: tick=0, index=0, active=0, shadow=0, pending=0, an=1111, seg=1111111, dp_n=1, load_ready=1.
REQ-025 One cycle after rst deasserts, an=1110 and seg SHALL show 0 (1000000).
REQ-026 Reset asserted mid-frame SHALL discard a pending word; no commit SHALL occur after release until a new transfer.

Configuration
REQ-027 Macro SEG7_LZ_BLANK_EN defined: digit k (k>=1) SHALL show seg=1111111 when nibbles k..3 are all zero and not (dp_en and dp_pos>=k); digit 0 is never blanked.
REQ-028 Macro SEG7_LZ_BLANK_EN undefined: every digit SHALL display its nibble, with no blanking logic present.

Structure
REQ-029 Package seg7_pkg SHALL hold the NUM_DIGITS=4 constant, the 16-entry segment constant table, and the display-word struct type {digits, dp_en, dp_pos}.
REQ-030 Combinational sub-module seg7_decode (nibble in, 7 active-low segments out) SHALL be instantiated once on the muxed nibble.

Verification
REQ-031 Reset: assert rst -> an=1111, seg=7F, dp_n=1, load_ready=1; release -> next cycle an=1110, seg=1000000.
REQ-032 Scan timing, TICK_DIV=4: an steps 1110, 1101, 1011, 0111, with each value held exactly 4 cycles and repeating.
REQ-033 Load 16'h1234, dp_en=1, dp_pos=2 mid-frame -> old word remains until the boundary; afterwards the index-2 slot shows seg=0100100 with dp_n=0.
REQ-034 Second load_valid while pending -> load_ready=0 and no capture; it is accepted the cycle after commit.
REQ-035 SEG7_LZ_BLANK_EN, word 16'h0007 with dp_en=0 -> digits 3..1 show 7F and digit 0 shows 1111000; with dp_en=1, dp_pos=2 -> digits 2 and 1 show 1000000.
REQ-036 Reset asserted one cycle before a boundary with pending=1 -> after release the active register is 0 and load_ready=1.
